// File: rtl/regfile_cmd_sequencer.sv
// Command sequencer driving an 8x8 register file: read operands, compute, write back.
// Optional readback-verify stage enabled by defining REGSEQ_READBACK_EN.
module regfile_cmd_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_rd,
  input  logic [ADDR_W-1:0] i_cmd_ra,
  input  logic [ADDR_W-1:0] i_cmd_rb,
  input  logic [DATA_W-1:0] i_cmd_imm,
  output logic [ADDR_W-1:0] o_read_reg1,
  output logic [ADDR_W-1:0] o_read_reg2,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  output logic [ADDR_W-1:0] o_write_reg,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_reg_write,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_flag_zero,
  output logic              o_flag_carry,
  output logic              o_mismatch
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWrite, StVerify} state_e;
  typedef enum logic [2:0] {OpLdi, OpMov, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNop} op_e;

  state_e              r_state;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_rd, r_ra, r_rb;
  logic [DATA_W-1:0]   r_imm, r_opa, r_opb, r_alu;
  logic                r_carry_stage;
  logic [ADDR_W-1:0]   r_read_reg1, r_read_reg2, r_write_reg;
  logic [DATA_W-1:0]   r_write_data, r_result;
  logic                r_reg_write, r_done, r_flag_zero, r_flag_carry;

  logic [DATA_W:0]     w_alu;
  logic                w_carry;
  logic                w_mismatch;

  // Carry/borrow is the extra top bit of the widened sum or difference.
  always_comb begin
    w_alu = '0;
    unique case (r_op)
      OpLdi:   w_alu = {1'b0, r_imm};
      OpMov:   w_alu = {1'b0, r_opa};
      OpAdd:   w_alu = {1'b0, r_opa} + {1'b0, r_opb};
      OpSub:   w_alu = {1'b0, r_opa} - {1'b0, r_opb};
      OpAnd:   w_alu = {1'b0, r_opa & r_opb};
      OpOr:    w_alu = {1'b0, r_opa | r_opb};
      OpXor:   w_alu = {1'b0, r_opa ^ r_opb};
      default: w_alu = '0;
    endcase
    w_carry = ((r_op == OpAdd) || (r_op == OpSub)) && w_alu[DATA_W];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_op          <= OpNop;
      r_rd          <= '0;
      r_ra          <= '0;
      r_rb          <= '0;
      r_imm         <= '0;
      r_opa         <= '0;
      r_opb         <= '0;
      r_alu         <= '0;
      r_carry_stage <= 1'b0;
      r_read_reg1   <= '0;
      r_read_reg2   <= '0;
      r_write_reg   <= '0;
      r_write_data  <= '0;
      r_reg_write   <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_flag_zero   <= 1'b0;
      r_flag_carry  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_op        <= op_e'(i_cmd_op);
            r_rd        <= i_cmd_rd;
            r_ra        <= i_cmd_ra;
            r_rb        <= i_cmd_rb;
            r_imm       <= i_cmd_imm;
            r_read_reg1 <= i_cmd_ra;
            r_read_reg2 <= i_cmd_rb;
            r_state     <= StRead;
          end
        end
        StRead: begin
          r_opa       <= i_data1;
          r_opb       <= i_data2;
          r_read_reg1 <= '0;
          r_read_reg2 <= '0;
          r_state     <= StExec;
        end
        StExec: begin
          r_alu         <= w_alu[DATA_W-1:0];
          r_carry_stage <= w_carry;
          r_reg_write   <= (r_op != OpNop);
          r_write_reg   <= (r_op != OpNop) ? r_rd : '0;
          r_write_data  <= (r_op != OpNop) ? w_alu[DATA_W-1:0] : '0;
`ifdef REGSEQ_READBACK_EN
          r_done        <= (r_op == OpNop);
`else
          r_done        <= 1'b1;
`endif
          r_state       <= StWrite;
        end
        StWrite: begin
          r_reg_write  <= 1'b0;
          r_write_reg  <= '0;
          r_write_data <= '0;
          r_done       <= 1'b0;
          if (r_op != OpNop) begin
            r_result     <= r_alu;
            r_flag_zero  <= (r_alu == '0);
            r_flag_carry <= r_carry_stage;
          end
`ifdef REGSEQ_READBACK_EN
          if (r_op != OpNop) begin
            r_read_reg1 <= r_rd;
            r_done      <= 1'b1;
            r_state     <= StVerify;
          end else begin
            r_state     <= StIdle;
          end
        end
        StVerify: begin
          r_read_reg1 <= '0;
          r_done      <= 1'b0;
          r_state     <= StIdle;
`else
          r_state      <= StIdle;
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef REGSEQ_READBACK_EN
  assign w_mismatch = (r_state == StVerify) && (i_data1 != r_alu);
`else
  assign w_mismatch = 1'b0;
`endif

  // Reset blanks every output in the same cycle, not one edge later.
  assign o_cmd_ready  = !i_rst && (r_state == StIdle);
  assign o_read_reg1  = i_rst ? '0 : r_read_reg1;
  assign o_read_reg2  = i_rst ? '0 : r_read_reg2;
  assign o_write_reg  = i_rst ? '0 : r_write_reg;
  assign o_write_data = i_rst ? '0 : r_write_data;
  assign o_reg_write  = !i_rst && r_reg_write;
  assign o_done       = !i_rst && r_done;
  assign o_result     = i_rst ? '0 : r_result;
  assign o_flag_zero  = !i_rst && r_flag_zero;
  assign o_flag_carry = !i_rst && r_flag_carry;
  assign o_mismatch   = !i_rst && w_mismatch;

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Directed bench for regfile_cmd_sequencer with a behavioural 8x8 register file.
module tb_regfile_cmd_sequencer;

`ifdef REGSEQ_READBACK_EN
  localparam int DoneLat = 4;
  localparam int Period  = 5;
  localparam int ExpMm6  = 1;
`else
  localparam int DoneLat = 3;
  localparam int Period  = 4;
  localparam int ExpMm6  = 0;
`endif

  localparam logic [2:0] LDI = 3'd0, MOV = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] AND = 3'd4, OR = 3'd5, XOR = 3'd6, NOP = 3'd7;

  logic       clk = 1'b0;
  logic       rst, valid, ready, reg_write, done, zero, carry, mismatch;
  logic [2:0] op, rd, ra, rb, rreg1, rreg2, wreg;
  logic [7:0] imm, data1, data2, wdata, result;
  logic [7:0] rf [8];
  logic       rf_clr, corrupt;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  regfile_cmd_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
    .i_cmd_op(op), .i_cmd_rd(rd), .i_cmd_ra(ra), .i_cmd_rb(rb), .i_cmd_imm(imm),
    .o_read_reg1(rreg1), .o_read_reg2(rreg2), .i_data1(data1), .i_data2(data2),
    .o_write_reg(wreg), .o_write_data(wdata), .o_reg_write(reg_write), .o_done(done),
    .o_result(result), .o_flag_zero(zero), .o_flag_carry(carry), .o_mismatch(mismatch)
  );

  // Register file model; optional fault flips bit 0 of writes to R7.
  always_ff @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (reg_write) begin
      rf[wreg] <= (corrupt && wreg == 3'd7) ? (wdata ^ 8'h01) : wdata;
    end
  end
  assign data1 = rf[rreg1];
  assign data2 = rf[rreg2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and check write-back, DONE timing and final result/flags.
  task automatic run_cmd(input string tag, input logic [2:0] c_op, input logic [2:0] c_rd,
                         input logic [2:0] c_ra, input logic [2:0] c_rb, input logic [7:0] c_imm,
                         input logic exp_we, input logic [7:0] exp_res, input logic exp_z,
                         input logic exp_c, input logic exp_mm);
    int we_cyc = 0;
    int we_cnt = 0;
    int done_cyc = 0;
    check({tag, "_ready"}, ready, 1);
    valid = 1'b1; op = c_op; rd = c_rd; ra = c_ra; rb = c_rb; imm = c_imm;
    step();
    valid = 1'b0;
    for (int n = 1; n <= 10 && done_cyc == 0; n++) begin
      if (reg_write) begin
        we_cnt++;
        if (we_cyc == 0) begin
          we_cyc = n;
          check({tag, "_wreg"}, wreg, c_rd);
          check({tag, "_wdata"}, wdata, exp_res);
        end
      end
      if (done) begin
        done_cyc = n;
        check({tag, "_mismatch"}, mismatch, exp_mm);
      end else begin
        step();
      end
    end
    check({tag, "_we_latency"}, we_cyc, exp_we ? 3 : 0);
    check({tag, "_we_pulses"}, we_cnt, exp_we ? 1 : 0);
    check({tag, "_done_latency"}, done_cyc, (c_op == NOP) ? 3 : DoneLat);
    step();
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, zero, exp_z);
    check({tag, "_carry"}, carry, exp_c);
    check({tag, "_ready_after"}, ready, 1);
  endtask

  initial begin
    int acc_t [3];
    int n_acc, we_cnt, done_cnt;
    rst = 1'b1; rf_clr = 1'b1; corrupt = 1'b0;
    valid = 1'b0; op = NOP; rd = '0; ra = '0; rb = '0; imm = '0;
    step(); step();
    check("rst_ready", ready, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 1'b0; rf_clr = 1'b0;
    #1;
    check("post_rst_ready", ready, 1);

    run_cmd("ldi_r3", LDI, 3'd3, 3'd0, 3'd0, 8'hA5, 1, 8'hA5, 0, 0, 0);
    run_cmd("ldi_r1", LDI, 3'd1, 3'd0, 3'd0, 8'hF0, 1, 8'hF0, 0, 0, 0);
    run_cmd("ldi_r2", LDI, 3'd2, 3'd0, 3'd0, 8'h20, 1, 8'h20, 0, 0, 0);
    run_cmd("add_r4", ADD, 3'd4, 3'd1, 3'd2, 8'h00, 1, 8'h10, 0, 1, 0);
    run_cmd("sub_r5", SUB, 3'd5, 3'd2, 3'd1, 8'h00, 1, 8'h30, 0, 1, 0);
    run_cmd("xor_r6", XOR, 3'd6, 3'd1, 3'd1, 8'h00, 1, 8'h00, 1, 0, 0);
    run_cmd("ldi_r1b", LDI, 3'd1, 3'd0, 3'd0, 8'h40, 1, 8'h40, 0, 0, 0);
    run_cmd("add_r1", ADD, 3'd1, 3'd1, 3'd1, 8'h00, 1, 8'h80, 0, 0, 0);
    check("rf_r1", rf[1], 8'h80);
    run_cmd("mov_r0", MOV, 3'd0, 3'd1, 3'd0, 8'h00, 1, 8'h80, 0, 0, 0);
    run_cmd("and_r2", AND, 3'd2, 3'd3, 3'd1, 8'h00, 1, 8'h80, 0, 0, 0);
    run_cmd("or_r2", OR, 3'd2, 3'd3, 3'd5, 8'h00, 1, 8'hB5, 0, 0, 0);

    // Back-to-back: VALID held high across three commands.
    n_acc = 0; we_cnt = 0; done_cnt = 0;
    valid = 1'b1; op = LDI; rd = 3'd2; ra = '0; rb = '0; imm = 8'h5A;
    for (int cyc = 0; cyc < 18; cyc++) begin
      logic acc;
      if (reg_write) we_cnt++;
      if (done) done_cnt++;
      acc = ready && valid;
      if (acc) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      step();
      if (acc) begin
        if (n_acc == 1) begin op = AND; rd = 3'd0; ra = 3'd2; rb = 3'd3; end
        else if (n_acc == 2) begin op = NOP; rd = 3'd5; ra = 3'd0; rb = 3'd0; end
        else valid = 1'b0;
      end
    end
    valid = 1'b0;
    check("q_accepts", n_acc, 3);
    check("q_gap1", acc_t[1] - acc_t[0], Period);
    check("q_gap2", acc_t[2] - acc_t[1], Period);
    check("q_reg_writes", we_cnt, 2);
    check("q_dones", done_cnt, 3);
    check("q_result", result, 8'h00);
    check("q_zero", zero, 1);
    check("q_rf_r5", rf[5], 8'h30);

    // Reset while an ADD sits in EXEC.
    valid = 1'b1; op = ADD; rd = 3'd4; ra = 3'd3; rb = 3'd3;
    step();
    valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_ready", ready, 0);
    check("rst_mid_result", result, 0);
    step();
    check("rst_mid_we", reg_write, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_zero", zero, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_ready_after", ready, 1);
    we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (reg_write) we_cnt++;
      if (done) done_cnt++;
      step();
    end
    check("rst_mid_no_we", we_cnt, 0);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_rf_r4", rf[4], 8'h10);
    check("rst_mid_flags", {zero, carry, result}, 10'h000);

    // Faulty write to R7: only a readback build can detect it.
    corrupt = 1'b1;
    run_cmd("mov_r7", MOV, 3'd7, 3'd0, 3'd0, 8'h00, 1, 8'h00, 1, 0, ExpMm6[0]);
    corrupt = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
